// File: rtl/frame_buffer_dbl_pkg.sv
// Shared types and constants for the double-buffered panel pixel store.
// Address is {row[4:0], col[5:0]}; pixel is {RGB0[5:3], RGB1[2:0]}.
package frame_buffer_dbl_pkg;

  localparam int FB_ADDR_W = 11;
  localparam int FB_DATA_W = 6;

  localparam int RGB0_MSB = 5;
  localparam int RGB0_LSB = 3;
  localparam int RGB1_MSB = 2;
  localparam int RGB1_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } fb_state_e;

endpackage

// File: rtl/frame_buffer_dbl_bank_ram.sv
// One pixel bank: synchronous write port, registered read port.
// Ports: clk, rst (clears read register only), we/wa/wd, ra/rd.
module fb_bank_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= mem[ra];
  end

  assign rd = rd_q;

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered pixel store: panel reads front bank, renderer
// writes/clears back bank, swaps only at a panel frame boundary.
module frame_buffer_dbl
  import frame_buffer_dbl_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] clr_color,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_bank,
  output logic              busy
);

  fb_state_e         state_q, state_d;
  logic              front_q, front_d;
  logic              ack_q, ack_d;
  logic              rd_sel_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] color_q, color_d;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rd0, rd1;

  assign wr_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q;
    color_d = color_q;
    we      = 1'b0;
    wa      = wr_addr;
    wd      = wr_data;
    unique case (state_q)
      IDLE: begin
        we = wr_valid && wr_ready;
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          color_d = clr_color;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        we = 1'b1;
        wa = cnt_q;
        wd = color_q;
        if (cnt_q == '1) state_d = IDLE;
        else             cnt_d   = cnt_q + 1'b1;
      end
      SWAP_WAIT: begin
        if (!swap_req) begin
          state_d = IDLE;
        end else if (frame_done) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      front_q  <= 1'b0;
      ack_q    <= 1'b0;
      rd_sel_q <= 1'b0;
      cnt_q    <= '0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      front_q  <= front_d;
      ack_q    <= ack_d;
      rd_sel_q <= front_q;
      cnt_q    <= cnt_d;
      color_q  <= color_d;
    end
  end

  // Back bank is the one not displayed.
  fb_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_b0 (
    .clk(clk), .rst(rst),
    .we(we && front_q), .wa(wa), .wd(wd),
    .ra(rd_addr), .rd(rd0)
  );

  fb_bank_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_b1 (
    .clk(clk), .rst(rst),
    .we(we && !front_q), .wa(wa), .wd(wd),
    .ra(rd_addr), .rd(rd1)
  );

  // Select with the bank that was front when the address was sampled.
  assign rd_data    = rd_sel_q ? rd1 : rd0;
  assign swap_ack   = ack_q;
  assign front_bank = front_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Self-checking bench for frame_buffer_dbl: vector table,
// read scoreboard and hand-written multi-cycle sequences.
module tb_frame_buffer_dbl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [10:0] wr_addr = '0;
  logic [5:0]  wr_data = '0;
  logic        clr_req = 1'b0;
  logic [5:0]  clr_color = '0;
  logic        swap_req = 1'b0;
  logic        swap_ack;
  logic        frame_done = 1'b0;
  logic [10:0] rd_addr = '0;
  logic [5:0]  rd_data;
  logic        front_bank;
  logic        busy;

  int pass_cnt = 0;
  int total = 0;
  logic [5:0] sb [$];

  typedef struct {
    logic [10:0] a;
    logic [5:0]  d;
    logic [5:0]  e;
  } vec_t;
  vec_t tv [8];

  always #5 clk = ~clk;

  frame_buffer_dbl dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_color(clr_color),
    .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_done(frame_done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .front_bank(front_bank), .busy(busy)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [10:0] a, logic [5:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    chk("wr_ready_on_write", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic rd_exp(logic [10:0] a, logic [5:0] e);
    sb.push_back(e);
    rd_addr = a;
    tick();
    if (sb.size() == 0) chk("rd_sb_empty", 1, 0);
    else chk("rd_data", rd_data, sb.pop_front());
  endtask

  task automatic do_swap();
    swap_req = 1'b1;
    tick();
    tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap_ack", swap_ack, 1);
    swap_req = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic exp_front;

    tv[0] = '{11'h000, 6'h01, 6'h01};
    tv[1] = '{11'h001, 6'h02, 6'h02};
    tv[2] = '{11'h03F, 6'h24, 6'h24};
    tv[3] = '{11'h005, 6'h01, 6'h09};
    tv[4] = '{11'h005, 6'h09, 6'h09};
    tv[5] = '{11'h400, 6'h38, 6'h38};
    tv[6] = '{11'h7FE, 6'h07, 6'h07};
    tv[7] = '{11'h7FF, 6'h3E, 6'h3E};

    // Reset values
    repeat (3) tick();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_front", front_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_wr_ready", wr_ready, 1);

    // Reset then swap, frame_done 5 cycles after swap_req
    wr(11'h040, 6'h2A);
    swap_req = 1'b1;
    tick();
    chk("swap_wait_busy", busy, 1);
    chk("swap_wait_wr_ready", wr_ready, 0);
    repeat (4) tick();
    chk("no_early_ack", swap_ack, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("swap1_ack", swap_ack, 1);
    chk("swap1_front", front_bank, 1);
    chk("swap1_busy", busy, 0);
    swap_req = 1'b0;
    tick();
    chk("ack_one_cycle", swap_ack, 0);
    rd_exp(11'h040, 6'h2A);

    // Double buffering plus swap-edge visibility
    wr(11'h040, 6'h15);
    rd_exp(11'h040, 6'h2A);
    rd_exp(11'h040, 6'h2A);
    swap_req = 1'b1;
    tick();
    frame_done = 1'b1;
    rd_addr = 11'h040;
    sb.push_back(6'h2A);
    tick();
    frame_done = 1'b0;
    swap_req = 1'b0;
    chk("swap2_ack", swap_ack, 1);
    chk("swap2_front", front_bank, 0);
    chk("rd_at_fd_old_bank", rd_data, sb.pop_front());
    rd_exp(11'h040, 6'h15);

    // Table-driven writes to B1, swap, read back
    for (int i = 0; i < 8; i++) wr(tv[i].a, tv[i].d);
    do_swap();
    chk("tbl_front", front_bank, 1);
    for (int i = 0; i < 8; i++) rd_exp(tv[i].a, tv[i].e);

    // Clear B0 with 0x3F; clr_req mid-clear is ignored
    clr_color = 6'h3F;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    clr_color = 6'h00;
    chk("clr_busy_rise", busy, 1);
    n = 0;
    bad = 0;
    while (busy && n < 3000) begin
      if (wr_ready) bad++;
      clr_req = (n == 500);
      n++;
      tick();
    end
    clr_req = 1'b0;
    chk("clr_cycles", n, 2048);
    chk("clr_wr_ready_low", bad, 0);
    chk("clr_done_wr_ready", wr_ready, 1);
    tick();
    chk("clr_no_second_pass", busy, 0);
    do_swap();
    chk("clr_front", front_bank, 0);
    rd_exp(11'd0, 6'h3F);
    rd_exp(11'd1023, 6'h3F);
    rd_exp(11'd2047, 6'h3F);
    rd_exp(11'h040, 6'h3F);

    // Priority: clear then swap; frame_done in CLEAR ignored
    clr_color = 6'h07;
    clr_req = 1'b1;
    swap_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (!busy || wr_ready || swap_ack) bad++;
      if (front_bank !== 1'b0) bad++;
      frame_done = (i % 300 == 150);
      tick();
    end
    frame_done = 1'b0;
    chk("prio_clear_phase", bad, 0);
    chk("prio_idle_gap", busy, 0);
    chk("prio_no_ack", swap_ack, 0);
    tick();
    chk("prio_swap_wait", busy, 1);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    swap_req = 1'b0;
    chk("prio_ack", swap_ack, 1);
    chk("prio_front", front_bank, 1);
    rd_exp(11'd0, 6'h07);
    rd_exp(11'd2047, 6'h07);

    // Swap withdrawn
    exp_front = 1'b1;
    swap_req = 1'b1;
    tick();
    tick();
    swap_req = 1'b0;
    tick();
    chk("wd_busy", busy, 0);
    chk("wd_wr_ready", wr_ready, 1);
    chk("wd_front", front_bank, exp_front);
    chk("wd_ack", swap_ack, 0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    chk("fd_idle_front", front_bank, exp_front);
    chk("fd_idle_ack", swap_ack, 0);

    // Reset at clear cycle 100
    clr_color = 6'h2D;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    chk("mid_clr_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mrst_front", front_bank, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_wr_ready", wr_ready, 0);
    rst = 1'b0;
    #1;
    wr(11'h123, 6'h11);
    chk("mrst_idle", busy, 0);
    do_swap();
    chk("mrst_swap_front", front_bank, 1);
    rd_exp(11'h123, 6'h11);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/frame_buffer_dbl.md
# frame_buffer_dbl

Double-buffered pixel store that sits directly upstream of the LED panel controller. The panel scan logic reads `{ROW, COL}`-addressed 6-bit pixels (`{RGB0, RGB1}`) from the front bank. The calculator-side renderer writes the back bank through a valid/ready port. Bank swaps happen only at a panel frame boundary, so the display never shows a partially drawn frame.

## Interface
- `ADDR_W`, default 11: pixel address width, `{row[4:0], col[5:0]}`, 2048 entries per bank.
- `DATA_W`, default 6: pixel width; bits [5:3] = RGB0 (upper half), bits [2:0] = RGB1 (lower half).
- `clk` in, 1: single clock for all logic.
- `rst` in, 1: synchronous, active-high reset.
- `wr_valid` in, 1: write request to the back bank.
- `wr_ready` out, 1: write port can accept.
- `wr_addr` in, ADDR_W: write address.
- `wr_data` in, DATA_W: write pixel.
- `clr_req` in, 1: single-cycle request to fill the back bank with `clr_color`.
- `clr_color` in, DATA_W: fill value, sampled when `clr_req` is accepted.
- `swap_req` in, 1: level request; held high until `swap_ack`.
- `swap_ack` out, 1: one-cycle pulse when the swap is performed.
- `frame_done` in, 1: one-cycle pulse from the panel controller after the last row is latched.
- `rd_addr` in, ADDR_W: panel read address.
- `rd_data` out, DATA_W: front-bank pixel.
- `front_bank` out, 1: index of the bank currently displayed.
- `busy` out, 1: high while in CLEAR or SWAP_WAIT.

## Operation
- Two banks, B0 and B1. Reads always use the front bank. Writes and clears always use the back bank (`~front_bank`).
- **IDLE** state:
  - `wr_ready`=1.
  - Write on `wr_valid & wr_ready`.
  - If `clr_req`=1, go to CLEAR. `clr_req` has priority over `swap_req`.
  - Else if `swap_req`=1, go to SWAP_WAIT.
  - A write presented in the same cycle as `clr_req` or `swap_req` is still accepted, because `wr_ready` is 1 in IDLE.
- **CLEAR** state:
  - `wr_ready`=0.
  - An 11-bit counter starts at 0 and writes `clr_color` to one address per cycle.
  - After address 2047 is written, return to IDLE.
  - `clr_req` is ignored while in CLEAR.
- **SWAP_WAIT** state:
  - `wr_ready`=0.
  - `frame_done` is sampled only in this state.
  - On `frame_done`: toggle `front_bank`, pulse `swap_ack` for one cycle, return to IDLE.
  - If `swap_req` drops before `frame_done`, return to IDLE without swapping.
- `frame_done` outside SWAP_WAIT has no effect.
- Memory contents are not reset and are undefined after power-up.
- Reset mid-operation:
  - In CLEAR: abort. The back bank is left partially filled and the state returns to IDLE.
  - In SWAP_WAIT: drop the pending swap; `front_bank` returns to 0.

## Timing
- Reset values:
  - state = IDLE, `front_bank`=0, `swap_ack`=0, `rd_data`=0, `busy`=0.
  - `wr_ready`=0 while `rst` is high and 1 on the first cycle after.
- Read latency: 1 cycle (registered output). `rd_data` at cycle n+1 = front bank[`rd_addr` at n].
- Swap visibility: the bank change applies to reads whose address is presented from the `swap_ack` cycle onward. A read issued in the cycle of the `frame_done` edge still returns the old bank.
- Write latency: the write commits at the accepting edge. A read of the same address returns new data only after a swap.
- Clear:
  - `busy` rises the cycle after `clr_req` is sampled.
  - Exactly 2048 CLEAR cycles.
  - `wr_ready` is 1 again on the cycle after the write to address 2047.
- Swap: `swap_ack` is asserted in the cycle after the edge where `frame_done` was sampled in SWAP_WAIT. It coincides with the first cycle back in IDLE, where `busy`=0.
- Counter wrap-around: the fill counter terminates at 2047 and does not wrap into another pass.

## Structure
- Shared package holds:
  - `FB_ADDR_W`=11, `FB_DATA_W`=6.
  - Pixel field positions: RGB0 = [5:3], RGB1 = [2:0].
  - State enum: IDLE, CLEAR, SWAP_WAIT.
- Sub-module `fb_bank_ram`: simple dual-port RAM, 2048×6, one synchronous write port and one registered read port. It is instantiated twice.
- The top level contains:
  - Write steering by `front_bank`.
  - Read mux on the registered outputs of the two RAMs, selected by `front_bank` delayed by one cycle.
  - FSM and fill counter.

## Test plan
- **Reset then swap:** reset, write 0x2A to addr 0x040, hold `swap_req`, pulse `frame_done` 5 cycles later. Expect `swap_ack` one cycle after, `front_bank`=1, and read of 0x040 returns 0x2A one cycle after the address is presented.
- **Double buffering:** after the first swap, write 0x15 to 0x040 in B0. Expect reads of 0x040 to still return 0x2A until the next swap, then 0x15.
- **Clear:** `clr_req` with `clr_color`=0x3F.
  - Expect `wr_ready`=0 and `busy`=1 for 2048 cycles.
  - After a swap, reads of addresses 0, 1023 and 2047 all return 0x3F.
- **Priority:** `clr_req` and `swap_req` in the same cycle. Expect the clear to finish first, then SWAP_WAIT. `frame_done` pulses during CLEAR are ignored, and the swap completes on the first `frame_done` after the clear.
- **Swap withdrawn:** raise `swap_req`, drop it before `frame_done`. Expect no `swap_ack`, `front_bank` unchanged, and `wr_ready` back to 1.
- **Reset mid-clear:** assert `rst` at clear cycle 100. Expect IDLE, `front_bank`=0 and `busy`=0 the next cycle. A subsequent write is accepted immediately.
